natural_log_scheduler: RTL
==========================

NATURAL_LOG_SCHEDULER -- requirements
Module: natural_log_scheduler

Interface
REQ-001 The block SHALL provide these parameters, one per line:
- NUM_REQ, default 4: number of requesters (2..8).
- LOG_LATENCY, default 4: cycles from operand issue to valid ln result at the shared core output.

REQ-002 The block SHALL provide these ports, one per line:
- clk  in  1  single system clock; all logic on rising edge.
- I_RSTn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_data  in  NUM_REQ x 24  per-requester operand, 8-bit fractional fixed point.
- req_ready  out  NUM_REQ  per-requester accept-capable flag.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  $clog2(NUM_REQ)  requester index owning the result.
- res_data  out  12  ln result, 8-bit fractional fixed point.

Function
REQ-003 A request from requester i SHALL be accepted on a rising edge where req_valid[i], req_ready[i] and grant[i] are all high.
REQ-004 req_ready[i] SHALL be low while requester i has an outstanding request; at most one outstanding request per requester.
REQ-005 The arbiter SHALL grant at most one request per cycle, round-robin: the search starts at pointer p, and p becomes (grantee+1) mod NUM_REQ after a grant; p is unchanged when there is no grant.
REQ-006 An accepted operand SHALL be registered into the shared natural_log core input on the acceptance edge; a tag pipeline of LOG_LATENCY stages (valid + id) SHALL track it.
REQ-007 res_valid SHALL pulse exactly LOG_LATENCY+1 cycles after acceptance, with res_id = grantee and res_data = core output, both registered.
REQ-008 The pending flag of requester i SHALL clear on the edge that asserts res_valid for i; req_ready[i] SHALL rise in that same cycle.
REQ-009 When no request is accepted, the core input SHALL hold its previous value and the tag stage-0 valid SHALL be 0.
REQ-010 res_id and res_data SHALL hold their last values while res_valid is low.
REQ-011 Back-to-back accepts from different requesters SHALL yield back-to-back res_valid pulses in acceptance order.
REQ-012 A requester deasserting req_valid without being granted SHALL be dropped without side effects.

Reset
REQ-013 While I_RSTn is low, the following SHALL all be 0, and the cache SHALL be invalid when compiled in:
- pending flags, tag pipeline, pointer p;
- res_valid, res_id, res_data;
- core input register.
REQ-014 Reset mid-operation SHALL discard in-flight requests; no res_valid SHALL appear for them after release.
REQ-015 req_ready SHALL be all-ones in the first cycle after reset release.

Configuration
REQ-016 With NATURAL_LOG_SCHEDULER_CACHE_EN defined, the block SHALL hold a per-requester cache entry (last operand, last result, valid flag).
REQ-017 With the macro defined, an accepted request whose operand equals a valid cache entry SHALL NOT be issued to the core.
- Its res_valid SHALL appear the cycle after acceptance, carrying the cached result.
- Its grant SHALL be suppressed in any cycle where tag stage LOG_LATENCY-1 is valid, so results never collide.
REQ-018 With the macro defined, the cache entry SHALL be written on each core result for that requester.
REQ-019 Without the macro, no cache storage SHALL exist and every accepted request SHALL be issued to the core.

Structure
REQ-020 A shared package natural_log_pkg SHALL hold:
- operand/result widths (24, 12);
- the tag struct {valid, id};
- the default NUM_REQ and LOG_LATENCY.
REQ-021 The round-robin grant logic SHALL be the sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).
REQ-022 The natural_log core SHALL be instantiated once inside the block.

Verification
REQ-023 Single request: req 0 sends 0x000200 (2.0) -> res_valid at acceptance+LOG_LATENCY+1, res_id=0, res_data=177 +/-2 LSB.
REQ-024 All four requesters valid in cycle 0 with p=0 -> grants 0,1,2,3 on consecutive cycles; four consecutive results in order; p=0 afterwards.
REQ-025 Requester 1 holds req_valid with an outstanding request -> req_ready[1]=0, no second accept until its res_valid cycle.
REQ-026 Reset asserted two cycles after acceptance of 0x0002B8 -> outputs 0 immediately; no res_valid for 15 cycles after release.
REQ-027 Cache enabled: requester 2 sends 0x0002B8 twice -> first result 256 +/-2 at latency LOG_LATENCY+1; second result identical, one cycle after acceptance, no core issue.
REQ-028 Cache enabled: hit pending while tag stage LOG_LATENCY-1 is valid -> grant delayed one cycle; no lost or merged res_valid.

Source files
------------

// File: rtl/natural_log_scheduler_pkg.sv
// Shared widths, tag type, defaults and the ln(1+f) segment table.
// The table is used by the natural_log core inside natural_log_scheduler.
package natural_log_pkg;

    localparam int OPERAND_W       = 24;
    localparam int RESULT_W        = 12;
    localparam int FRAC_W          = 8;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_LOG_LATENCY = 4;
    localparam int TAG_ID_W        = 3;
    localparam int LN2_Q16         = 45426;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // ln(1 + j/16) scaled by 2^16, breakpoints for linear interpolation
    function automatic logic [15:0] ln_seg(input logic [4:0] j);
        case (j)
            5'd0:    ln_seg = 16'd0;
            5'd1:    ln_seg = 16'd3973;
            5'd2:    ln_seg = 16'd7719;
            5'd3:    ln_seg = 16'd11262;
            5'd4:    ln_seg = 16'd14624;
            5'd5:    ln_seg = 16'd17821;
            5'd6:    ln_seg = 16'd20870;
            5'd7:    ln_seg = 16'd23783;
            5'd8:    ln_seg = 16'd26573;
            5'd9:    ln_seg = 16'd29248;
            5'd10:   ln_seg = 16'd31818;
            5'd11:   ln_seg = 16'd34292;
            5'd12:   ln_seg = 16'd36675;
            5'd13:   ln_seg = 16'd38975;
            5'd14:   ln_seg = 16'd41197;
            5'd15:   ln_seg = 16'd43345;
            5'd16:   ln_seg = 16'd45426;
            default: ln_seg = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/natural_log_scheduler_core.sv
// natural_log core: ln of an 8-bit-fraction operand; results for operands below 1.0 clamp to 0.
// LATENCY counts the caller's operand register, so LATENCY-1 stages live here.
module natural_log
    import natural_log_pkg::*;
#(
    parameter int LATENCY = DEF_LOG_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPERAND_W-1:0] i_operand,
    output logic [RESULT_W-1:0]  o_result
);

    logic [4:0]          w_msb;
    logic                w_ge_one;
    logic [15:0]         w_frac;
    logic [15:0]         w_lo;
    logic [15:0]         w_hi;
    logic [27:0]         w_prod;
    logic [16:0]         w_ln_m;
    logic [20:0]         w_total;
    logic [RESULT_W-1:0] w_ln;

    // leading-one position gives the power-of-two exponent
    always_comb begin
        w_msb = 5'd0;
        for (int b = 0; b < OPERAND_W; b++) begin
            w_msb = i_operand[b] ? 5'(b) : w_msb;
        end
    end

    assign w_ge_one = |i_operand[OPERAND_W-1:FRAC_W];
    assign w_frac   = 16'((i_operand << (5'd23 - w_msb)) >> 7);
    assign w_lo     = ln_seg({1'b0, w_frac[15:12]});
    assign w_hi     = ln_seg({1'b0, w_frac[15:12]} + 5'd1);
    assign w_prod   = 28'(w_hi - w_lo) * 28'(w_frac[11:0]);
    assign w_ln_m   = 17'(w_lo) + 17'(w_prod >> 12);
    assign w_total  = 21'(w_msb - 5'd8) * 21'(LN2_Q16) + 21'(w_ln_m);
    assign w_ln     = w_ge_one ? 12'((w_total + 21'd128) >> 8) : 12'd0;

    generate
        if (LATENCY > 1) begin : g_pipe
            logic [RESULT_W-1:0] r_pipe [LATENCY-1];

            // delay line keeping the result aligned with the scheduler tag pipeline
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < LATENCY-1; s++) begin
                        r_pipe[s] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_ln;
                    for (int s = 1; s < LATENCY-1; s++) begin
                        r_pipe[s] <= r_pipe[s-1];
                    end
                end
            end

            assign o_result = r_pipe[LATENCY-2];
        end else begin : g_comb
            assign o_result = w_ln;
        end
    endgenerate

endmodule

// File: rtl/natural_log_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after i_ptr.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic w_found;

    // wrap-around search starting at the pointer
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && i_req[PTR_W'((int'(i_ptr) + k) % N)]) begin
                o_grant[PTR_W'((int'(i_ptr) + k) % N)] = 1'b1;
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/natural_log_scheduler.sv
// Round-robin scheduler sharing one natural_log core among NUM_REQ requesters.
// Optional per-requester result cache: define NATURAL_LOG_SCHEDULER_CACHE_EN.
module natural_log_scheduler
    import natural_log_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int LOG_LATENCY = DEF_LOG_LATENCY
) (
    input  logic                              clk,
    input  logic                              I_RSTn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][OPERAND_W-1:0] req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              res_valid,
    output logic [$clog2(NUM_REQ)-1:0]        res_id,
    output logic [RESULT_W-1:0]               res_data
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   r_pend;
    logic [ID_W-1:0]      r_ptr;
    logic [OPERAND_W-1:0] r_core_in;
    tag_t                 r_tag [LOG_LATENCY];
    tag_t                 w_tail;
    logic [NUM_REQ-1:0]   w_req;
    logic [NUM_REQ-1:0]   w_grant;
    logic [NUM_REQ-1:0]   w_hit;
    logic [ID_W-1:0]      w_gnt_idx;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic                 w_accept;
    logic                 w_gnt_hit;
    logic                 w_issue;
    logic [RESULT_W-1:0]  w_core_out;
    logic [RESULT_W-1:0]  w_hit_res;

    assign w_tail    = r_tag[LOG_LATENCY-1];
    assign req_ready = ~r_pend;
    // a cache hit answers next cycle, so it must wait while a core result is due then
    assign w_req     = req_valid & ~r_pend & ~(w_hit & {NUM_REQ{w_tail.valid}});
    assign w_accept  = |w_grant;
    assign w_gnt_hit = |(w_grant & w_hit);
    assign w_issue   = w_accept & ~w_gnt_hit;
    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + ID_W'(1);

    rr_arbiter #(.N(NUM_REQ), .PTR_W(ID_W)) u_arb (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    natural_log #(.LATENCY(LOG_LATENCY)) u_core (
        .clk       (clk),
        .rst_n     (I_RSTn),
        .i_operand (r_core_in),
        .o_result  (w_core_out)
    );

    // one-hot grant to index
    always_comb begin
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_gnt_idx = w_grant[i] ? ID_W'(i) : w_gnt_idx;
        end
    end

    // arbitration pointer and per-requester outstanding flags
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_ptr  <= '0;
            r_pend <= '0;
        end else begin
            r_ptr <= w_accept ? w_ptr_nxt : r_ptr;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_issue && w_grant[i]) begin
                    r_pend[i] <= 1'b1;
                end else if (w_tail.valid && (w_tail.id == TAG_ID_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end else begin
                    r_pend[i] <= r_pend[i];
                end
            end
        end
    end

    // core operand register and tag pipeline
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_core_in <= '0;
            for (int s = 0; s < LOG_LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_core_in      <= w_issue ? req_data[w_gnt_idx] : r_core_in;
            r_tag[0].valid <= w_issue;
            r_tag[0].id    <= TAG_ID_W'(w_gnt_idx);
            for (int s = 1; s < LOG_LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // result registers: core result or cache hit, never both in one cycle
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
        end else if (w_tail.valid) begin
            res_valid <= 1'b1;
            res_id    <= ID_W'(w_tail.id);
            res_data  <= w_core_out;
        end else if (w_accept && w_gnt_hit) begin
            res_valid <= 1'b1;
            res_id    <= w_gnt_idx;
            res_data  <= w_hit_res;
        end else begin
            res_valid <= 1'b0;
            res_id    <= res_id;
            res_data  <= res_data;
        end
    end

`ifdef NATURAL_LOG_SCHEDULER_CACHE_EN
    logic [NUM_REQ-1:0]   r_cache_vld;
    logic [OPERAND_W-1:0] r_cache_op  [NUM_REQ];
    logic [RESULT_W-1:0]  r_cache_res [NUM_REQ];
    logic [OPERAND_W-1:0] r_issued_op [NUM_REQ];

    // operand kept until its core result is written into the cache
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_cache_vld <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_cache_op[i]  <= '0;
                r_cache_res[i] <= '0;
                r_issued_op[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_issued_op[i] <= (w_issue && w_grant[i]) ? req_data[i] : r_issued_op[i];
                if (w_tail.valid && (w_tail.id == TAG_ID_W'(i))) begin
                    r_cache_vld[i] <= 1'b1;
                    r_cache_op[i]  <= r_issued_op[i];
                    r_cache_res[i] <= w_core_out;
                end else begin
                    r_cache_vld[i] <= r_cache_vld[i];
                    r_cache_op[i]  <= r_cache_op[i];
                    r_cache_res[i] <= r_cache_res[i];
                end
            end
        end
    end

    // operand match against each requester's cached entry
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hit[i] = r_cache_vld[i] && (req_data[i] == r_cache_op[i]);
        end
    end

    assign w_hit_res = r_cache_res[w_gnt_idx];
`else
    assign w_hit     = '0;
    assign w_hit_res = '0;
`endif

endmodule
